// File: rtl/arb2_pkg.sv
// Shared defaults and source encodings for the two-client request buffer.
package arb2_pkg;
  localparam int   DATA_W_DEF = 8;
  localparam int   DEPTH_DEF  = 4;
  localparam logic SRC_1      = 1'b0;
  localparam logic SRC_2      = 1'b1;
endpackage

// File: rtl/arb2_req_fifo.sv
// Per-client FIFO: push lands next cycle, head is the registered oldest entry.
// A full FIFO refuses a push even if it pops in the same cycle (full comes from count only).
module arb2_req_fifo
  import arb2_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/arb2_req_buf.sv
// Two client FIFOs feeding one output register via an external 2-way arbiter; push-to-out_valid 2 cycles.
// Requests drop while the output is stalled; ARB2_REQ_BUF_ERR_EN adds a sticky gnt_err port.
module arb2_req_buf
  import arb2_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in2_valid,
  output logic              in2_ready,
  input  logic [DATA_W-1:0] in2_data,
  output logic              req1,
  output logic              req2,
  input  logic              gnt1,
  input  logic              gnt2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src
`ifdef ARB2_REQ_BUF_ERR_EN
  ,
  output logic              gnt_err
`endif
);
  logic              full1, full2, empty1, empty2;
  logic [DATA_W-1:0] head1, head2;
  logic              load_ok, take1, take2;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_src_q, out_src_d;

  assign in1_ready = ~full1;
  assign in2_ready = ~full2;
  assign load_ok   = ~out_valid_q | out_ready;
  assign req1      = ~empty1 & load_ok;
  assign req2      = ~empty2 & load_ok;
  // Client 1 wins a double grant; client 2 keeps its head untouched.
  assign take1     = gnt1 & req1;
  assign take2     = gnt2 & req2 & ~take1;

  arb2_req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (in1_valid),
    .pop   (take1),
    .din   (in1_data),
    .full  (full1),
    .empty (empty1),
    .head  (head1)
  );

  arb2_req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo2 (
    .clk   (clk),
    .rst   (rst),
    .push  (in2_valid),
    .pop   (take2),
    .din   (in2_data),
    .full  (full2),
    .empty (empty2),
    .head  (head2)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (take1) begin
      out_valid_d = 1'b1;
      out_data_d  = head1;
      out_src_d   = SRC_1;
    end else if (take2) begin
      out_valid_d = 1'b1;
      out_data_d  = head2;
      out_src_d   = SRC_2;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

`ifdef ARB2_REQ_BUF_ERR_EN
  logic gnt_err_q, gnt_err_d;

  assign gnt_err_d = gnt_err_q | (gnt1 & gnt2) | (gnt1 & ~req1) | (gnt2 & ~req2);

  always_ff @(posedge clk) begin
    if (rst) gnt_err_q <= 1'b0;
    else     gnt_err_q <= gnt_err_d;
  end

  assign gnt_err = gnt_err_q;
`endif
endmodule

// File: doc/arb2_req_buf.md
ARB2_REQ_BUF -- requirements
Module: arb2_req_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, entries per client FIFO; power of 2, minimum 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have ports in1_valid/in2_valid  input  1  client payload offered.
REQ-006 SHALL have ports in1_ready/in2_ready  output  1  client FIFO can accept.
REQ-007 SHALL have ports in1_data/in2_data  input  DATA_W  client payload.
REQ-008 SHALL have ports req1/req2  output  1  request to the downstream 2-way arbiter.
REQ-009 SHALL have ports gnt1/gnt2  input  1  combinational grants returned by the arbiter in the same cycle.
REQ-010 SHALL have port out_valid  output  1  output register holds a payload.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the output payload.
REQ-012 SHALL have port out_data  output  DATA_W  granted payload.
REQ-013 SHALL have port out_src  output  1  source of out_data: 0 = client 1, 1 = client 2.

Function
REQ-014 SHALL hold one FIFO per client; a push occurs when inN_valid & inN_ready at the clock edge.
REQ-015 SHALL drive inN_ready = FIFO N not full, from the registered count only; a full FIFO refuses a push even when it pops in the same cycle.
REQ-016 SHALL define load_ok = !out_valid | out_ready.
REQ-017 SHALL drive reqN = FIFO N not empty & load_ok, so a grant always results in a pop.
REQ-018 SHALL, on gntN & reqN, pop the FIFO N head and load it into out_data, with out_src = N-1, and set out_valid, all at the same edge.
REQ-019 SHALL, if both gnt1 and gnt2 are high, service gnt1 only and leave FIFO 2 unchanged.
REQ-020 SHALL ignore gntN while reqN is low.
REQ-021 SHALL clear out_valid on out_valid & out_ready when no grant loads a new payload in that cycle.
REQ-022 SHALL sustain one transfer per cycle while out_ready stays high.
REQ-023 SHALL have a minimum latency of 2 cycles: push at edge N gives out_valid high after edge N+1.
REQ-024 SHALL preserve per-client order; FIFO pointers wrap modulo DEPTH.
REQ-025 SHALL use count width clog2(DEPTH)+1.
REQ-026 SHALL hold out_data and out_src stable while out_valid & !out_ready.

Reset
REQ-027 SHALL, on rst high at a clock edge, empty both FIFOs and clear pointers.
REQ-028 SHALL reset out_valid=0, out_data=0 and out_src=0; hence req1=req2=0 and in1_ready=in2_ready=1 after reset.
REQ-029 SHALL let reset asserted mid-transfer discard all buffered and output payloads with no partial state retained.
REQ-030 SHALL give rst priority over any push, pop or load in the same cycle.

Configuration
REQ-031 SHALL, with ARB2_REQ_BUF_ERR_EN defined, add output port gnt_err (1 bit, sticky, reset 0); it sets on gnt1&gnt2, or on gntN while reqN is low.
REQ-032 SHALL, without ARB2_REQ_BUF_ERR_EN, have no gnt_err port and unchanged datapath behaviour.

Structure
REQ-033 SHALL place DATA_W and DEPTH defaults and the constants SRC_1=0 and SRC_2=1 in shared package arb2_pkg.
REQ-034 SHALL implement each client FIFO as sub-module arb2_req_fifo (push/pop/full/empty/head), instantiated twice.

Verification
REQ-035 SHALL cover: reset, then in1 pushes 0xA5 with out_ready=1 and the arbiter granting -> out_valid=1, out_data=0xA5, out_src=0 two cycles after the push.
REQ-036 SHALL cover: out_ready=0, 4 pushes to in1 -> in1_ready=0 after the 4th push, and a 5th offer is not accepted; raising out_ready drains 4 items in push order.
REQ-037 SHALL cover: both FIFOs hold 2 items, arbiter alternates grants, out_ready=1 -> out_src sequence 0,1,0,1 on consecutive cycles with per-client order kept.
REQ-038 SHALL cover: out_valid=1 with out_ready=0 for 3 cycles -> req1=req2=0 and out_data stable; no pops.
REQ-039 SHALL cover: rst asserted with 3 items buffered -> next cycle out_valid=0, in1_ready=in2_ready=1, req1=req2=0.
REQ-040 SHALL cover, with ARB2_REQ_BUF_ERR_EN: forced gnt1=gnt2=1 while both request -> only FIFO 1 pops, and gnt_err=1 stays set until rst.
